// File: rtl/fir_pkg.sv
// Shared FIR definitions: loader state encoding, default filter geometry
// and the bytes-per-coefficient helper used by loader and datapath.
package fir_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, SWAP} state_t;

   localparam int FIR_LENGTH  = 200;
   localparam int FIR_COEFF_W = 17;

   function automatic int bytes_per_coeff(input int coeff_w);
      return (coeff_w + 7) / 8;
   endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Byte-stream bus carrying coefficient frames into the loader.
interface fir_coeff_loader_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/coeff_bank.sv
// LENGTH x COEFF_W coefficient bank: one write port, one registered read port.
// Out-of-range read addresses return zero.
module coeff_bank
   import fir_pkg::*;
#(
   parameter  int LENGTH  = FIR_LENGTH,
   parameter  int COEFF_W = FIR_COEFF_W,
   localparam int IDX_W   = $clog2(LENGTH)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_addr,
   input  logic [COEFF_W-1:0] wr_data,
   input  logic [IDX_W-1:0]   rd_addr,
   output logic [COEFF_W-1:0] rd_data
);

   logic [COEFF_W-1:0] mem [LENGTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < LENGTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                     rd_data <= '0;
      else if (int'(rd_addr) < LENGTH) rd_data <= mem[rd_addr];
      else                              rd_data <= '0;
   end

endmodule

// File: rtl/fir_coeff_loader.sv
// Assembles little-endian coefficient bytes into a shadow bank and flips it
// active on a complete frame. Optional trailing XOR byte: COEFF_CHECKSUM_EN.
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter  int LENGTH          = FIR_LENGTH,
   parameter  int COEFF_W         = FIR_COEFF_W,
   localparam int BYTES_PER_COEFF = bytes_per_coeff(COEFF_W),
   localparam int IDX_W           = $clog2(LENGTH)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   fir_coeff_loader_if.slave     in_bus,
   input  logic [IDX_W-1:0]      rd_addr,
   output logic [COEFF_W-1:0]    rd_coeff,
   output logic                  coeff_updated,
   output logic                  frame_error,
   output logic                  busy
);

   localparam int BC_W = $clog2(BYTES_PER_COEFF + 1);

   state_t               state_reg, state_next;
   logic [BC_W-1:0]      byte_cnt_reg, byte_cnt_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [COEFF_W-1:0]   asm_reg, asm_next, word;
   logic                 sel_reg, sel_next, rd_sel_reg;
   logic                 upd_reg, upd_next, err_reg, err_next;
   logic                 wr_en, accept, take_payload, coeff_done, payload_done;
   logic [1:0][COEFF_W-1:0] bank_rd;
`ifdef COEFF_CHECKSUM_EN
   logic                 pay_done_reg, pay_done_next;
   logic [7:0]           xor_reg, xor_next;
`endif

   assign in_bus.in_ready = reset_n && (state_reg != SWAP);
   assign accept          = in_bus.in_valid && in_bus.in_ready;
   assign coeff_done      = (byte_cnt_reg == BC_W'(BYTES_PER_COEFF - 1));
   assign payload_done    = coeff_done && (idx_reg == IDX_W'(LENGTH - 1));
`ifdef COEFF_CHECKSUM_EN
   assign take_payload = accept && (state_reg == IDLE || state_reg == LOAD) && !pay_done_reg;
`else
   assign take_payload = accept && (state_reg == IDLE || state_reg == LOAD);
`endif

   // Incoming byte overlays its lane; bits at or above COEFF_W simply never land.
   always_comb begin
      for (int j = 0; j < COEFF_W; j++)
         word[j] = (j / 8 == int'(byte_cnt_reg)) ? in_bus.in_data[j % 8] : asm_reg[j];
   end

   always_comb begin
      state_next    = state_reg;
      byte_cnt_next = byte_cnt_reg;
      idx_next      = idx_reg;
      asm_next      = asm_reg;
      sel_next      = sel_reg;
      upd_next      = 1'b0;
      err_next      = 1'b0;
      wr_en         = 1'b0;
`ifdef COEFF_CHECKSUM_EN
      pay_done_next = pay_done_reg;
      xor_next      = xor_reg;
`endif
      case (state_reg)
         IDLE, LOAD: begin
            if (accept) begin
               state_next = LOAD;
`ifdef COEFF_CHECKSUM_EN
               if (pay_done_reg) begin
                  if (!in_bus.in_last)                 state_next = DRAIN;
                  else if (in_bus.in_data == xor_reg) state_next = SWAP;
                  else begin
                     err_next   = 1'b1;
                     state_next = IDLE;
                  end
               end else begin
                  xor_next = xor_reg ^ in_bus.in_data;
                  if (in_bus.in_last) begin
                     err_next   = 1'b1;
                     state_next = IDLE;
                  end else if (payload_done) begin
                     pay_done_next = 1'b1;
                  end
               end
`else
               if (payload_done) begin
                  state_next = in_bus.in_last ? SWAP : DRAIN;
               end else if (in_bus.in_last) begin
                  err_next   = 1'b1;
                  state_next = IDLE;
               end
`endif
            end
         end
         DRAIN: begin
            if (accept && in_bus.in_last) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end
         end
         SWAP: begin
            sel_next   = ~sel_reg;
            upd_next   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (take_payload) begin
         asm_next = word;
         wr_en    = coeff_done;
         if (coeff_done) begin
            byte_cnt_next = '0;
            if (!payload_done) idx_next = idx_reg + 1'b1;
         end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
         end
      end

      // Any return to IDLE rearms the counters for the next frame.
      if (state_next == IDLE) begin
         byte_cnt_next = '0;
         idx_next      = '0;
         asm_next      = '0;
`ifdef COEFF_CHECKSUM_EN
         pay_done_next = 1'b0;
         xor_next      = '0;
`endif
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         byte_cnt_reg <= '0;
         idx_reg      <= '0;
         asm_reg      <= '0;
         sel_reg      <= 1'b0;
         rd_sel_reg   <= 1'b0;
         upd_reg      <= 1'b0;
         err_reg      <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
         pay_done_reg <= 1'b0;
         xor_reg      <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         byte_cnt_reg <= byte_cnt_next;
         idx_reg      <= idx_next;
         asm_reg      <= asm_next;
         sel_reg      <= sel_next;
         rd_sel_reg   <= sel_reg;
         upd_reg      <= upd_next;
         err_reg      <= err_next;
`ifdef COEFF_CHECKSUM_EN
         pay_done_reg <= pay_done_next;
         xor_reg      <= xor_next;
`endif
      end
   end

   // Bank gi is active while sel_reg == gi; the other one is the shadow being written.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      coeff_bank #(.LENGTH(LENGTH), .COEFF_W(COEFF_W)) u_bank (
         .clock   (clock),
         .reset_n (reset_n),
         .wr_en   (wr_en && (sel_reg != 1'(gi))),
         .wr_addr (idx_reg),
         .wr_data (word),
         .rd_addr (rd_addr),
         .rd_data (bank_rd[gi])
      );
   end

   assign rd_coeff      = bank_rd[rd_sel_reg];
   assign coeff_updated = upd_reg;
   assign frame_error   = err_reg;
   assign busy          = (state_reg != IDLE);

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Writer side of the FIR coefficient interface. Receives a byte stream of filter coefficients and assembles each coefficient into a shadow bank.
- Atomically swaps the shadow bank into the active bank when a valid frame completes.
- Serves active coefficients to the filter datapath through a registered read port, so coefficients can change at run time without glitching the filter.

Parameters:
- LENGTH, 200, number of coefficients per frame (filter taps)
- COEFF_W, 17, coefficient width in bits
- BYTES_PER_COEFF, derived as (COEFF_W+7)/8 (3 at default); not overridable
- IDX_W, derived as $clog2(LENGTH); not overridable

Ports:
- clock  in  1  rising-edge system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  byte-stream valid
- in_ready  out  1  byte-stream ready
- in_data  in  8  byte-stream payload
- in_last  in  1  marks final byte of a frame
- rd_addr  in  IDX_W  coefficient index requested by the filter
- rd_coeff  out  COEFF_W  active coefficient at rd_addr, one cycle latency
- coeff_updated  out  1  one-cycle pulse: active bank replaced
- frame_error  out  1  one-cycle pulse: frame rejected
- busy  out  1  high while a frame is in progress (LOAD, DRAIN, SWAP)

Behaviour:
- Reset (async assert, sync release): state IDLE; both banks all zero; rd_coeff=0, in_ready=0 while reset_n low; coeff_updated=0, frame_error=0, busy=0. Reset mid-frame discards the frame, and the active bank returns to zero.
- Handshake: a byte transfers when in_valid && in_ready on a rising clock edge. in_ready=1 in IDLE, LOAD and DRAIN; in_ready=0 in SWAP. The source must hold in_data and in_last stable while in_valid && !in_ready.
- Byte packing: little-endian within each coefficient; byte k supplies bits [8k+7:8k]. Bits at or above COEFF_W in the last byte are ignored. Coefficient 0 arrives first. A byte counter and a coefficient index counter run up to BYTES_PER_COEFF-1 and LENGTH-1, with no wrap past LENGTH.
- States:
  - IDLE: first accepted byte moves to LOAD (busy=1). If that byte has in_last=1 and LENGTH*BYTES_PER_COEFF>1, pulse frame_error and stay in IDLE.
  - LOAD: each completed coefficient is written to shadow[idx].
    - Accepted byte N=LENGTH*BYTES_PER_COEFF with in_last=1: go to SWAP.
    - in_last=1 before byte N: frame_error pulse next cycle, go to IDLE. Shadow contents are undefined for the next frame; they are fully overwritten.
    - Byte N accepted with in_last=0: go to DRAIN.
  - DRAIN: accept and discard bytes until in_last=1, then frame_error pulse and go to IDLE.
  - SWAP: one cycle. The active bank takes the shadow contents (bank-select flip or copy; the implementation may choose). coeff_updated pulses in the same cycle the new bank becomes visible. Then go to IDLE.
- Read port: rd_coeff <= active[rd_addr] every cycle. A read issued in the SWAP cycle returns the old value; a read issued on the following cycle returns the new value. rd_addr>=LENGTH returns 0.
- The active bank never mixes old and new frames. A rejected frame leaves the active bank unchanged.
- coeff_updated and frame_error never assert in the same cycle.

Optional Feature:
- COEFF_CHECKSUM_EN
- Defined: the frame carries one extra trailing byte, so frame length is N+1. That byte must equal the XOR of all N payload bytes. On mismatch: frame_error pulse, no swap. Early or late in_last is handled as in the base behaviour, with N+1 as the expected length.
- Undefined: no checksum byte; the frame is exactly N bytes.

Decomposition:
- Shared package fir_pkg holds:
  - state enum {IDLE, LOAD, DRAIN, SWAP}
  - default constants LENGTH=200 and COEFF_W=17, also used by the fir datapath
  - function computing BYTES_PER_COEFF
- One natural sub-module: coeff_bank, a LENGTH x COEFF_W register bank with write port and registered read port, instantiated twice (shadow and active) or as a ping-pong pair.

Test Plan (LENGTH=4, COEFF_W=17, N=12):
- Reset, then read addr 0..3 -> rd_coeff=0 for all; in_ready=1 after release; busy=0.
- Send bytes for coeffs {0x00001, 0x1FFFF, 0x0A5A5, 0x10000} with in_last on byte 12 -> coeff_updated one pulse; reads return those values; a byte-2 value of 0xFE yields bit16=0.
- Valid frame with in_valid toggled every other cycle, plus rd_addr=1 held across SWAP -> old value in the SWAP cycle, new value the cycle after; in_ready=0 only in SWAP.
- in_last on byte 7 -> frame_error pulse; active bank unchanged; next valid frame loads correctly.
- 14 bytes with in_last on byte 14 -> DRAIN, frame_error pulse, active unchanged, busy low afterwards.
- Assert reset_n=0 at byte 6 of a frame -> all outputs at reset values immediately; active bank reads 0. With COEFF_CHECKSUM_EN, a wrong checksum byte -> frame_error and no swap.
